// File: rtl/flash_pkg.sv
// Shared flash opcodes and responder state encoding.
// The boot-loader initiator imports the same opcodes, so both ends stay in sync.
package flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_CMD_RDID = 8'h9F;
    localparam logic [7:0] FLASH_CMD_RDSR = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_FETCH,
        S_DATA_OUT,
        S_ID_OUT,
        S_ST_OUT,
        S_IGNORE
    } flash_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Optional synchronizer for the SPI pins followed by a previous-value register.
// Produces the single-cycle SCK-rise and CS-fall strobes used by the responder FSM.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic flash_clk,
    input  logic flash_cs,
    input  logic flash_mosi,
    output logic sck_rise,
    output logic cs_fall,
    output logic cs_high,
    output logic mosi_s
);

    logic [2:0] pins_raw;
    logic [2:0] pins_s;
    logic       sck_prev;
    logic       cs_prev;

    assign pins_raw = {flash_clk, flash_cs, flash_mosi};

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign pins_s = pins_raw;
        end else begin : g_sync
            logic [2:0] stg [SYNC_STAGES];
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
                end else begin
                    stg[0] <= pins_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
                end
            end
            assign pins_s = stg[SYNC_STAGES-1];
        end
    endgenerate

    // CS history clears to 0 so a CS still low after reset never looks like a new fall.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sck_prev <= 1'b0;
            cs_prev  <= 1'b0;
        end else begin
            sck_prev <= pins_s[2];
            cs_prev  <= pins_s[1];
        end
    end

    assign sck_rise = pins_s[2] & ~sck_prev;
    assign cs_fall  = ~pins_s[1] & cs_prev;
    assign cs_high  = pins_s[1];
    assign mosi_s   = pins_s[0];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: answers READ / RDID / RDSR, streams READ data from a sync byte memory.
//  state      | meaning
//  S_IDLE     | waiting for CS falling edge
//  S_CMD      | shifting in the 8-bit opcode
//  S_ADDR     | shifting in the 24-bit address
//  S_FETCH    | first byte read in flight
//  S_DATA_OUT | streaming bytes, prefetching the next one
//  S_ID_OUT   | shifting out JEDEC ID, then zeros
//  S_ST_OUT   | repeating the status byte
//  S_IGNORE   | unknown opcode, silent until CS high
module spi_flash_responder
    import flash_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 24,
    parameter int          SYNC_STAGES = 0,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  flash_clk,
    input  logic                  flash_cs,
    input  logic                  flash_mosi,
    output logic                  flash_miso,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [7:0]            mem_rd_data,
    output logic                  active
);

    flash_state_t state, state_nxt;
    logic         sck_rise, cs_fall, cs_high, mosi_s;
    logic [22:0]  shift_in;
    logic [4:0]   cmd_cnt;
    logic [2:0]   bit_cnt;
    logic [23:0]  out_sr;
    logic [7:0]   hold;
    logic         rd_pend;
    logic [7:0]   opcode;
    logic [23:0]  addr_full;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flash_clk (flash_clk),
        .flash_cs  (flash_cs),
        .flash_mosi(flash_mosi),
        .sck_rise  (sck_rise),
        .cs_fall   (cs_fall),
        .cs_high   (cs_high),
        .mosi_s    (mosi_s)
    );

    assign opcode     = {shift_in[6:0], mosi_s};
    assign addr_full  = {shift_in, mosi_s};
    assign flash_miso = out_sr[23];
    assign active     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        if (cs_high) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cs_fall) state_nxt = S_CMD;
                S_CMD: begin
                    if (sck_rise && cmd_cnt == 5'd7) begin
                        case (opcode)
                            FLASH_CMD_READ: state_nxt = S_ADDR;
                            FLASH_CMD_RDID: state_nxt = S_ID_OUT;
                            FLASH_CMD_RDSR: state_nxt = S_ST_OUT;
                            default:        state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR:  if (sck_rise && cmd_cnt == 5'd31) state_nxt = S_FETCH;
                S_FETCH: if (rd_pend) state_nxt = S_DATA_OUT;
                default: state_nxt = state;
            endcase
        end
    end

    // Output bits occupy out_sr[23]; ID mode uses all 24 bits, byte modes use the top 8.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            shift_in  <= '0;
            cmd_cnt   <= '0;
            bit_cnt   <= '0;
            out_sr    <= '0;
            hold      <= '0;
            rd_pend   <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_rd_en <= 1'b0;
            rd_pend   <= mem_rd_en;
            if (cs_high) begin
                out_sr <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            cmd_cnt <= '0;
                            bit_cnt <= '0;
                            out_sr  <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            shift_in <= addr_full[22:0];
                            cmd_cnt  <= cmd_cnt + 5'd1;
                            if (cmd_cnt == 5'd7 && opcode == FLASH_CMD_RDID)
                                out_sr <= JEDEC_ID;
                            else if (cmd_cnt == 5'd7 && opcode == FLASH_CMD_RDSR)
                                out_sr <= {STATUS_BYTE, 16'h0000};
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            shift_in <= addr_full[22:0];
                            cmd_cnt  <= cmd_cnt + 5'd1;
                            if (cmd_cnt == 5'd31) begin
                                mem_addr  <= ADDR_WIDTH'(addr_full);
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (rd_pend) begin
                            out_sr  <= {mem_rd_data, 16'h0000};
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA_OUT: begin
                        if (rd_pend) hold <= mem_rd_data;
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                out_sr <= {hold, 16'h0000};
                            else
                                out_sr <= {out_sr[22:0], 1'b0};
                            // bit 0 now on the wire: fetch the next byte while it is sampled
                            if (bit_cnt == 3'd6) begin
                                mem_addr  <= mem_addr + 1'b1;
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                    S_ID_OUT: begin
                        if (sck_rise) out_sr <= {out_sr[22:0], 1'b0};
                    end
                    S_ST_OUT: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                out_sr <= {STATUS_BYTE, 16'h0000};
                            else
                                out_sr <= {out_sr[22:0], 1'b0};
                        end
                    end
                    default: out_sr <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: table of transactions plus hand-written wrap, abort and reset cases.
// Two instances share the SPI bus: default widths, and an 8-bit address / 0xA5 status variant.
module tb_spi_flash_responder;
    import flash_pkg::*;

    localparam int HALF = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        flash_clk = 1'b0;
    logic        flash_cs = 1'b1;
    logic        flash_mosi = 1'b0;
    logic        miso0, miso8, rd_en0, rd_en8, active0, active8;
    logic [23:0] addr0;
    logic [7:0]  addr8;
    logic [7:0]  rdata0 = 8'h00;
    logic [7:0]  rdata8 = 8'h00;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] log0 [$];
    logic [7:0]  log8 [$];
    logic [7:0]  exp_q [$];

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          nbytes;
        logic [39:0] exp;
        int          n_rd;
    } vec_t;

    vec_t vec [6];

    always #5 sys_clk = ~sys_clk;

    spi_flash_responder dut0 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .flash_clk  (flash_clk),
        .flash_cs   (flash_cs),
        .flash_mosi (flash_mosi),
        .flash_miso (miso0),
        .mem_addr   (addr0),
        .mem_rd_en  (rd_en0),
        .mem_rd_data(rdata0),
        .active     (active0)
    );

    spi_flash_responder #(.ADDR_WIDTH(8), .STATUS_BYTE(8'hA5)) dut8 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .flash_clk  (flash_clk),
        .flash_cs   (flash_cs),
        .flash_mosi (flash_mosi),
        .flash_miso (miso8),
        .mem_addr   (addr8),
        .mem_rd_en  (rd_en8),
        .mem_rd_data(rdata8),
        .active     (active8)
    );

    always @(posedge sys_clk) begin
        if (rd_en0) rdata0 <= mem[addr0[7:0]];
        if (rd_en8) rdata8 <= mem[addr8];
    end

    always @(negedge sys_clk) begin
        if (rd_en0) log0.push_back(addr0);
        if (rd_en8) log8.push_back(addr8);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called on a negedge with SCK low; returns both MISO values seen just before the rise.
    task automatic xfer_bit(input logic tx, output logic r0, output logic r8);
        flash_mosi = tx;
        repeat (HALF) @(negedge sys_clk);
        r0 = miso0;
        r8 = miso8;
        flash_clk = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        flash_clk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] r0, output logic [7:0] r8);
        logic b0, b8;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], b0, b8);
            r0[i] = b0;
            r8[i] = b8;
        end
    endtask

    task automatic start_cmd(input logic [7:0] op);
        logic [7:0] d0, d8;
        @(negedge sys_clk) flash_cs = 1'b0;
        repeat (2) @(negedge sys_clk);
        xfer_byte(op, d0, d8);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] d0, d8;
        xfer_byte(a[23:16], d0, d8);
        xfer_byte(a[15:8], d0, d8);
        xfer_byte(a[7:0], d0, d8);
    endtask

    task automatic end_cmd;
        @(negedge sys_clk) flash_cs = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin : main
        logic [7:0] d0, d8;
        logic       b0, b8;

        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h31 + i);

        vec[0] = '{FLASH_CMD_READ, 24'h000000, 4, 40'h3132333400, 5};
        vec[1] = '{FLASH_CMD_RDID, 24'h000000, 5, 40'hEF40180000, 0};
        vec[2] = '{FLASH_CMD_RDSR, 24'h000000, 3, 40'h0000000000, 0};
        vec[3] = '{8'h42,          24'h000000, 2, 40'h0000000000, 0};
        vec[4] = '{FLASH_CMD_READ, 24'h000000, 1, 40'h3100000000, 2};
        vec[5] = '{FLASH_CMD_READ, 24'h000010, 2, 40'h4142000000, 3};

        repeat (3) @(negedge sys_clk);
        check("reset miso", 32'(miso0), 32'd0);
        check("reset rd_en", 32'(rd_en0), 32'd0);
        check("reset addr", 32'(addr0), 32'd0);
        check("reset active", 32'(active0), 32'd0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int v = 0; v < 6; v++) begin
            log0.delete();
            start_cmd(vec[v].op);
            if (vec[v].op == FLASH_CMD_READ) send_addr(vec[v].addr);
            for (int k = 0; k < vec[v].nbytes; k++) exp_q.push_back(vec[v].exp[39-8*k -: 8]);
            for (int k = 0; k < vec[v].nbytes; k++) begin
                xfer_byte(8'h00, d0, d8);
                check($sformatf("v%0d byte%0d", v, k), 32'(d0), 32'(exp_q.pop_front()));
            end
            check($sformatf("v%0d active", v), 32'(active0), 32'd1);
            end_cmd;
            check($sformatf("v%0d idle active", v), 32'(active0), 32'd0);
            check($sformatf("v%0d idle miso", v), 32'(miso0), 32'd0);
            check($sformatf("v%0d rd count", v), 32'(log0.size()), 32'(vec[v].n_rd));
            if (vec[v].n_rd > 0) begin
                check($sformatf("v%0d first rd addr", v), 32'(log0[0]), 32'(vec[v].addr));
                check($sformatf("v%0d last rd addr", v), 32'(log0[log0.size()-1]),
                      32'(vec[v].addr + 24'(vec[v].nbytes)));
            end
        end

        // 8-bit address wrap on the narrow instance
        log8.delete();
        start_cmd(FLASH_CMD_READ);
        send_addr(24'h0000FE);
        exp_q.push_back(8'h2F); exp_q.push_back(8'h30);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        for (int k = 0; k < 4; k++) begin
            xfer_byte(8'h00, d0, d8);
            check($sformatf("wrap byte%0d", k), 32'(d8), 32'(exp_q.pop_front()));
        end
        end_cmd;
        check("wrap rd count", 32'(log8.size()), 32'd5);
        check("wrap addr FF", 32'(log8[1]), 32'h0FF);
        check("wrap addr 00", 32'(log8[2]), 32'h000);

        // status byte repeats for as long as CS stays low
        start_cmd(FLASH_CMD_RDSR);
        for (int k = 0; k < 3; k++) begin
            xfer_byte(8'h00, d0, d8);
            check($sformatf("status byte%0d", k), 32'(d8), 32'hA5);
        end
        end_cmd;

        // CS high partway through the address
        log0.delete();
        start_cmd(FLASH_CMD_READ);
        for (int i = 0; i < 12; i++) xfer_bit(1'b0, b0, b8);
        @(negedge sys_clk) flash_cs = 1'b1;
        @(negedge sys_clk);
        check("abort active", 32'(active0), 32'd0);
        check("abort rd count", 32'(log0.size()), 32'd0);
        repeat (3) @(negedge sys_clk);
        start_cmd(FLASH_CMD_READ);
        send_addr(24'h000002);
        xfer_byte(8'h00, d0, d8);
        check("after abort byte0", 32'(d0), 32'h33);
        xfer_byte(8'h00, d0, d8);
        check("after abort byte1", 32'(d0), 32'h34);
        end_cmd;

        // reset in the middle of DATA_OUT with CS held low
        start_cmd(FLASH_CMD_READ);
        send_addr(24'h000000);
        xfer_byte(8'h00, d0, d8);
        check("pre reset byte", 32'(d0), 32'h31);
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, b0, b8);
        @(negedge sys_clk) sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid reset miso", 32'(miso0), 32'd0);
        check("mid reset active", 32'(active0), 32'd0);
        sys_rst_n = 1'b1;
        log0.delete();
        for (int k = 0; k < 2; k++) begin
            xfer_byte(8'h00, d0, d8);
            check($sformatf("post reset byte%0d", k), 32'(d0), 32'd0);
            check($sformatf("post reset active%0d", k), 32'(active0), 32'd0);
        end
        check("post reset rd count", 32'(log0.size()), 32'd0);
        end_cmd;
        start_cmd(FLASH_CMD_READ);
        send_addr(24'h000000);
        xfer_byte(8'h00, d0, d8);
        check("recovered byte", 32'(d0), 32'h31);
        end_cmd;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
